// File: rtl/dma_pkg.sv
// Shared types and constants for the burst DMA controller.
package dma_pkg;

    localparam int DMA_WORD_SIZE = 16;

    localparam logic DIR_M2E = 1'b0;
    localparam logic DIR_E2M = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        XFER = 3'd2,
        REL  = 3'd3,
        DONE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/dma_addr_gen.sv
// Transfer bookkeeping: latched base/length, word and burst counters,
// registered address/index outputs and end-of-burst/transfer flags.
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int WORD_SIZE = DMA_WORD_SIZE,
    parameter int BURST     = 4,
    parameter int IDX_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 burst_clr,
    input  logic                 advance,
    input  logic [WORD_SIZE-1:0] length,
    input  logic [WORD_SIZE-1:0] base,
    output logic [WORD_SIZE-1:0] memory_address,
    output logic [IDX_W-1:0]     index,
    output logic                 last_word,
    output logic                 burst_end
);

    logic [WORD_SIZE-1:0] base_q;
    logic [WORD_SIZE-1:0] len_q;
    logic [WORD_SIZE-1:0] cnt;
    logic [WORD_SIZE-1:0] bcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q         <= '0;
            len_q          <= '0;
            cnt            <= '0;
            bcnt           <= '0;
            memory_address <= '0;
            index          <= '0;
        end else if (load) begin
            base_q <= base;
            len_q  <= length;
            cnt    <= '0;
            bcnt   <= '0;
        end else begin
            if (burst_clr)
                bcnt <= '0;
            // Address and index report the word being strobed this cycle.
            if (advance) begin
                memory_address <= base_q + cnt;
                index          <= cnt[IDX_W-1:0];
                cnt            <= cnt + WORD_SIZE'(1);
                bcnt           <= bcnt + WORD_SIZE'(1);
            end
        end
    end

    assign last_word = (cnt == len_q);
    assign burst_end = (bcnt == WORD_SIZE'(BURST));

endmodule

// File: rtl/dma_burst_ctrl.sv
// Burst DMA controller: requests the bus, moves up to BURST words per grant,
// releases the bus for one cycle between bursts and raises a done interrupt.
module dma_burst_ctrl
    import dma_pkg::*;
#(
    parameter int WORD_SIZE = DMA_WORD_SIZE,
    parameter int BURST     = 4,
    parameter int IDX_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 begin_dma,
    input  logic                 dir,
    input  logic [WORD_SIZE-1:0] length,
    input  logic [WORD_SIZE-1:0] target_address,
    input  logic                 bg,
    output logic                 br,
    output logic [WORD_SIZE-1:0] memory_address,
    output logic                 mtoe,
    output logic                 etom,
    output logic [IDX_W-1:0]     index,
    output logic                 busy,
    output logic                 dma_done
);

    dma_state_e state;
    logic       dir_q;
    logic       last_word;
    logic       burst_end;
    logic       load;
    logic       burst_clr;
    logic       advance;

    assign load      = (state == IDLE) && begin_dma;
    assign burst_clr = (state == REQ) && bg;
    assign advance   = (state == XFER) && bg && !last_word && !burst_end;

    dma_addr_gen #(
        .WORD_SIZE (WORD_SIZE),
        .BURST     (BURST),
        .IDX_W     (IDX_W)
    ) u_addr_gen (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .burst_clr      (burst_clr),
        .advance        (advance),
        .length         (length),
        .base           (target_address),
        .memory_address (memory_address),
        .index          (index),
        .last_word      (last_word),
        .burst_end      (burst_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dir_q    <= DIR_M2E;
            br       <= 1'b0;
            mtoe     <= 1'b0;
            etom     <= 1'b0;
            busy     <= 1'b0;
            dma_done <= 1'b0;
        end else begin
            mtoe     <= 1'b0;
            etom     <= 1'b0;
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (begin_dma) begin
                        dir_q <= dir;
                        if (length != '0) begin
                            state <= REQ;
                            br    <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (bg)
                        state <= XFER;
                end
                XFER: begin
                    // Burst end takes priority over a revoked grant.
                    if (last_word || burst_end) begin
                        br    <= 1'b0;
                        state <= last_word ? DONE : REL;
                    end else if (bg) begin
                        mtoe <= (dir_q == DIR_M2E);
                        etom <= (dir_q == DIR_E2M);
                    end
                end
                REL: begin
                    br    <= 1'b1;
                    state <= REQ;
                end
                DONE: begin
                    dma_done <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
